// File: rtl/neuron_pkg.sv
// Shared types, format defaults and arithmetic helpers for the serial neuron.
package neuron_pkg;

    localparam int N_DEF  = 4;
    localparam int QM_DEF = 12;
    localparam int QN_DEF = 20;
    localparam int WM_DEF = 6;
    localparam int WN_DEF = 10;
    localparam int OB_DEF = 8;

    // Widest accumulator/output the activation helper can handle.
    localparam int ACC_MAX = 128;
    localparam int OB_MAX  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic signed [ACC_MAX-1:0] acc_max_t;

    typedef struct packed {
        logic              sat;
        logic [OB_MAX-1:0] data;
    } act_t;

    function automatic int acc_width(input int prod_w, input int n);
        return prod_w + $clog2(n) + 1;
    endfunction

    // Floor to integer, clamp negatives to zero and saturate at 2^ob-1.
    function automatic act_t relu_sat(input acc_max_t acc, input int frac, input int ob);
        acc_max_t ip;
        acc_max_t lim;
        acc_max_t top;
        act_t     res;
        ip       = acc >>> frac;
        lim      = '0;
        lim[ob]  = 1'b1;
        top      = lim - acc_max_t'(1);
        res.sat  = 1'b0;
        res.data = '0;
        if (acc[ACC_MAX-1]) begin
            res.sat  = 1'b0;
            res.data = '0;
        end else if (ip >= lim) begin
            res.sat  = 1'b1;
            res.data = top[OB_MAX-1:0];
        end else begin
            res.sat  = 1'b0;
            res.data = ip[OB_MAX-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_neuron_ctrl_mac_unit.sv
// Shared signed multiplier with accumulator register; clear beats bias load beats accumulate.
module mac_unit
    import neuron_pkg::*;
#(
    parameter int IW         = 32,
    parameter int WW         = 16,
    parameter int ACC_W      = 51,
    parameter int BIAS_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    load_i,
    input  logic                    en_i,
    input  logic signed [IW-1:0]    bias_i,
    input  logic signed [IW-1:0]    a_i,
    input  logic signed [WW-1:0]    b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int P = IW + WW;

    logic signed [P-1:0]     prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] bias_ext_s;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    assign prod_s     = a_i * b_i;
    assign prod_ext_s = {{(ACC_W-P){prod_s[P-1]}}, prod_s};
    // Bias arrives in input format; shifting by the weight fraction lines it up with products.
    assign bias_ext_s = {{(ACC_W-IW-BIAS_SHIFT){bias_i[IW-1]}}, bias_i, {BIAS_SHIFT{1'b0}}};

    // Accumulator next-state selection.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (load_i) begin
            acc_d = bias_ext_s;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/serial_neuron_ctrl.sv
// Time-multiplexed neuron: one MAC sequenced over N pairs, then bias, ReLU and saturation.
module serial_neuron_ctrl
    import neuron_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int QM = QM_DEF,
    parameter int QN = QN_DEF,
    parameter int WM = WM_DEF,
    parameter int WN = WN_DEF,
    parameter int OB = OB_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     start_ready,
    input  logic [N*(QM+QN)-1:0]     in_data,
    input  logic [N*(WM+WN)-1:0]     weights,
    input  logic [QM+QN-1:0]         bias,
    input  logic                     abort,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OB-1:0]            out_data,
    output logic                     sat,
    output logic                     busy
);

    localparam int IW    = QM + QN;
    localparam int WW    = WM + WN;
    localparam int P     = IW + WW;
    localparam int ACC_W = acc_width(P, N);
    localparam int F     = QN + WN;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N-1:0][IW-1:0]     in_q;
    logic [N-1:0][WW-1:0]     w_q;
    logic [IW-1:0]            bias_q;
    logic                     out_valid_q, out_valid_d;
    logic [OB-1:0]            out_data_q, out_data_d;
    logic                     sat_q, sat_d;

    logic                     accept_s;
    logic                     clr_s;
    logic                     load_s;
    logic                     en_s;
    logic signed [ACC_W-1:0]  acc_s;
    act_t                     act_s;

    assign accept_s = (state_q == IDLE) && start && !abort;

    mac_unit #(
        .IW         (IW),
        .WW         (WW),
        .ACC_W      (ACC_W),
        .BIAS_SHIFT (WN)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_s),
        .load_i (load_s),
        .en_i   (en_s),
        .bias_i (signed'(load_s ? bias : bias_q)),
        .a_i    (signed'(in_q[idx_q])),
        .b_i    (signed'(w_q[idx_q])),
        .acc_o  (acc_s)
    );

    assign act_s = relu_sat(acc_max_t'(acc_s), F, OB);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; abort overrides every other request.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = start ? MAC : IDLE;
                MAC:     state_d = (idx_q == IDX_W'(N-1)) ? ACT : MAC;
                ACT:     state_d = DONE;
                DONE:    state_d = out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM output decode: status from registered state, MAC controls.
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        clr_s       = abort;
        load_s      = 1'b0;
        en_s        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                load_s      = start && !abort;
            end
            MAC: begin
                busy = 1'b1;
                en_s = !abort;
            end
            ACT:     busy = 1'b1;
            DONE:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Pair index next-state.
    always_comb begin
        idx_d = idx_q;
        if (accept_s) begin
            idx_d = '0;
        end else if ((state_q == MAC) && !abort) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // Result port next-state; data and sat only move at the ACT edge.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sat_d       = sat_q;
        if (abort) begin
            out_valid_d = 1'b0;
        end else if (state_q == ACT) begin
            out_valid_d = 1'b1;
            out_data_d  = act_s.data[OB-1:0];
            sat_d       = act_s.sat;
        end else if ((state_q == DONE) && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    // Operand capture on an accepted start only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q   <= '0;
            w_q    <= '0;
            bias_q <= '0;
        end else if (accept_s) begin
            in_q   <= in_data;
            w_q    <= weights;
            bias_q <= bias;
        end else begin
            in_q   <= in_q;
            w_q    <= w_q;
            bias_q <= bias_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_serial_neuron_ctrl.sv
// Scoreboard bench for serial_neuron_ctrl at default parameters.
module tb_serial_neuron_ctrl;

    localparam int N  = 4;
    localparam int IW = 32;
    localparam int WW = 16;
    localparam int OB = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              start_ready;
    logic [N*IW-1:0]   in_data;
    logic [N*WW-1:0]   weights;
    logic [IW-1:0]     bias;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [OB-1:0]     out_data;
    logic              sat;
    logic              busy;

    int checks_cnt = 0;
    int fail_cnt   = 0;
    logic [OB:0] exp_q[$];

    always #5 clk = ~clk;

    serial_neuron_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_ready (start_ready),
        .in_data     (in_data),
        .weights     (weights),
        .bias        (bias),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sat         (sat),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic in Q.30, floor, ReLU, clamp to 255.
    function automatic logic [OB:0] model(input logic [N*IW-1:0] x, input logic [N*WW-1:0] w,
                                          input logic [IW-1:0] b);
        longint acc;
        longint ip;
        logic signed [IW-1:0] xi;
        logic signed [WW-1:0] wi;
        logic signed [IW-1:0] bs;
        bs  = b;
        acc = longint'(bs) <<< 10;
        for (int i = 0; i < N; i++) begin
            xi  = x[i*IW +: IW];
            wi  = w[i*WW +: WW];
            acc = acc + longint'(xi) * longint'(wi);
        end
        ip = acc >>> 30;
        if (acc < 0)        return {1'b0, 8'd0};
        else if (ip >= 256) return {1'b1, 8'hFF};
        else                return {1'b0, ip[7:0]};
    endfunction

    task automatic start_op(input logic [N*IW-1:0] x, input logic [N*WW-1:0] w,
                            input logic [IW-1:0] b, input bit push, input logic [OB:0] exp);
        check("start_ready_idle", start_ready, 1);
        in_data = x;
        weights = w;
        bias    = b;
        start   = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        start   = 1'b0;
        in_data = ~x;
        weights = ~w;
        bias    = ~b;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_result();
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, N + 1);
    endtask

    task automatic take_result(input string tag);
        logic [OB:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_data"}, out_data, e[OB-1:0]);
            check({tag, "_sat"}, sat, e[OB]);
        end
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_idle"}, start_ready, 1);
    endtask

    logic [N*IW-1:0] x;
    logic [N*WW-1:0] w;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        weights   = '0;
        bias      = '0;
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", sat, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", start_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // All ones: 4.0
        start_op({4{32'h0010_0000}}, {4{16'h0400}}, 32'h0, 1'b1, {1'b0, 8'd4});
        wait_result();
        take_result("ones");

        // Negative sum clamps to zero
        start_op({32'h0, 32'h0, 32'h0, 32'hFFD0_0000}, {16'h0, 16'h0, 16'h0, 16'h0400},
                 32'h0, 1'b1, {1'b0, 8'd0});
        wait_result();
        take_result("neg");

        // 400 saturates
        start_op({4{32'h0640_0000}}, {4{16'h0400}}, 32'h0, 1'b1, {1'b1, 8'hFF});
        wait_result();
        take_result("satur");

        // Bias only, 2.5 floors to 2
        start_op('0, {4{16'h0400}}, 32'h0028_0000, 1'b1, {1'b0, 8'd2});
        wait_result();
        take_result("bias");

        // Backpressure with an ignored start during DONE
        out_ready = 1'b0;
        start_op({4{32'h0020_0000}}, {4{16'h0400}}, 32'h0, 1'b1, {1'b0, 8'd8});
        wait_result();
        for (int i = 0; i < 10; i++) begin
            start   = (i == 3);
            in_data = {4{32'h0640_0000}};
            weights = {4{16'h0400}};
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 8);
            check("bp_sat", sat, 0);
            check("bp_ready", start_ready, 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        take_result("bp");
        repeat (3) @(negedge clk);
        check("bp_no_queue_valid", out_valid, 0);
        check("bp_no_queue_busy", busy, 0);
        start_op({4{32'h0640_0000}}, {4{16'h0400}}, 32'h0, 1'b1, {1'b1, 8'hFF});
        wait_result();
        take_result("post_bp");

        // Reset during the second MAC cycle
        start_op({4{32'h0010_0000}}, {4{16'h0400}}, 32'h0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_data", out_data, 0);
        check("mrst_sat", sat, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", start_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op({4{32'h0030_0000}}, {4{16'h0400}}, 32'h0, 1'b1, {1'b0, 8'd12});
        wait_result();
        take_result("after_rst");

        // Abort during MAC: no result, last output retained
        start_op({4{32'h0640_0000}}, {4{16'h0400}}, 32'h0, 1'b0, '0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", start_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        check("abort_keep_data", out_data, 12);
        check("abort_keep_sat", sat, 0);
        start_op({32'h0010_0000, 32'h0020_0000, 32'h0030_0000, 32'h0040_0000},
                 {4{16'h0800}}, 32'h0008_0000, 1'b1, {1'b0, 8'd20});
        wait_result();
        take_result("after_abort");

        // Random operands scored against the reference model
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) begin
                x[i*IW +: IW] = 32'($urandom_range(0, 32'h0380_0000)) - 32'h0080_0000;
                w[i*WW +: WW] = 16'($urandom_range(0, 32'h0800)) - 16'h0200;
            end
            start_op(x, w, 32'($urandom_range(0, 32'h0100_0000)) - 32'h0080_0000, 1'b1,
                     model(x, w, 32'h0));
            exp_q[exp_q.size()-1] = model(x, w, ~bias);
            wait_result();
            take_result("rand");
        end

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
